// File: rtl/action_ctrl.sv
// action_ctrl: debounces the player buttons, keeps the board cursor and
// posts reveal/flag/restart commands to the CPU through an ACTION/ACK
// four-phase mailbox, with a one-entry holding buffer for presses that
// arrive while a previous action is still in flight.
module action_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_W            = 18,
  parameter int unsigned COLS            = 16,
  parameter int unsigned ROWS            = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       BTN_LEFT,
  input  logic       BTN_RIGHT,
  input  logic       BTN_REVEAL,
  input  logic       BTN_FLAG,
  input  logic       BTN_RESTART,
  input  logic [7:0] ACK,
  output logic [7:0] ACTION,
  output logic [5:0] CURSOR,
  output logic       BUSY,
  output logic       OVERFLOW
);

  localparam int unsigned NB = 7;
  localparam int unsigned B_UP      = 0;
  localparam int unsigned B_DOWN    = 1;
  localparam int unsigned B_LEFT    = 2;
  localparam int unsigned B_RIGHT   = 3;
  localparam int unsigned B_REVEAL  = 4;
  localparam int unsigned B_FLAG    = 5;
  localparam int unsigned B_RESTART = 6;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POST  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  logic [NB-1:0]   raw_btn;
  logic [NB-1:0]   sync1_q, sync2_q, db_q, db_prev_q, press;
  logic [DB_W-1:0] cnt_q [NB];

  state_t          state_q;
  logic [7:0]      action_q, buf_q, cmd_code;
  logic            buf_valid_q, busy_q, ovf_q;
  logic            cmd_valid, post_restart, buf_store, ovf_set;
  logic [CW-1:0]   col_q, col_mv, col_d;
  logic [RW-1:0]   row_q, row_mv, row_d;
  logic [5:0]      cursor_q, cursor_d;

  assign raw_btn = {BTN_RESTART, BTN_FLAG, BTN_REVEAL, BTN_RIGHT,
                    BTN_LEFT, BTN_DOWN, BTN_UP};

  // Synchronize each button and accept a new level only after it has been stable.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw_btn;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          db_q[i]  <= ~db_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  // Decode press events into a cursor move and a command, and decide what the mailbox does with it.
  always_comb begin
    col_mv = col_q;
    row_mv = row_q;
    if (press[B_UP])
      row_mv = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
    else if (press[B_DOWN])
      row_mv = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    else if (press[B_LEFT])
      col_mv = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
    else if (press[B_RIGHT])
      col_mv = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);

    cmd_valid = press[B_RESTART] | press[B_REVEAL] | press[B_FLAG];
    cmd_code  = 8'h00;
    if (press[B_RESTART])     cmd_code = 8'hC0;
    else if (press[B_REVEAL]) cmd_code = {2'b01, cursor_q};
    else if (press[B_FLAG])   cmd_code = {2'b10, cursor_q};

    // In IDLE the buffered entry goes out first; a fresh press in that same
    // cycle takes over the slot being vacated instead of being lost.
    post_restart = (state_q == S_IDLE) &&
                   (buf_valid_q ? (buf_q[7:6] == 2'b11) : (cmd_valid && press[B_RESTART]));
    buf_store = cmd_valid && ((state_q != S_IDLE) ? !buf_valid_q : buf_valid_q);
    ovf_set   = cmd_valid && (state_q != S_IDLE) && buf_valid_q;

    col_d    = post_restart ? '0 : col_mv;
    row_d    = post_restart ? '0 : row_mv;
    cursor_d = 6'(32'(row_d) * COLS + 32'(col_d));
  end

  // Mailbox FSM with holding buffer, cursor registers and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      action_q    <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      cursor_q    <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      cursor_q <= cursor_d;
      case (state_q)
        S_IDLE: begin
          if (buf_valid_q) begin
            action_q    <= buf_q;
            buf_valid_q <= 1'b0;
            state_q     <= S_POST;
            busy_q      <= 1'b1;
          end else if (cmd_valid) begin
            action_q <= cmd_code;
            state_q  <= S_POST;
            busy_q   <= 1'b1;
          end
        end
        S_POST: begin
          if (ACK == action_q) begin
            action_q <= '0;
            state_q  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (ACK == 8'h00) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          action_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
      if (buf_store) begin
        buf_q       <= cmd_code;
        buf_valid_q <= 1'b1;
      end
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  assign ACTION   = action_q;
  assign CURSOR   = cursor_q;
  assign BUSY     = busy_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: doc/action_ctrl.md
Name: action_ctrl

Overview:
- Producer end of the CPU action/ack mailbox. The data memory maps `ACTION` as the read-only CPU port at address 246 and `ACK` as the CPU-writable register at address 247.
- Debounces the player push-buttons and keeps the board cursor, wrapping in both directions.
- Encodes reveal, flag and restart commands into an action byte and holds it until the CPU completes a four-phase handshake through `ACK`.
- Drives the cursor index to the display for highlighting.

Parameters:
- `DEBOUNCE_CYCLES`, 250000: cycles a synchronized button level must stay stable before it is accepted (10 ms at 25 MHz).
- `DB_W`, 18: width of the debounce counters. Must hold `DEBOUNCE_CYCLES-1`.
- `COLS`, 16: board columns.
- `ROWS`, 4: board rows. `COLS*ROWS` must be 64 or less.

Ports:
- `CLK`  in  1  system clock; all logic is rising-edge.
- `RESET_N`  in  1  asynchronous, active-low reset. Single clock domain.
- `BTN_UP`, `BTN_DOWN`, `BTN_LEFT`, `BTN_RIGHT`  in  1 each  raw movement buttons; asynchronous, active-high.
- `BTN_REVEAL`, `BTN_FLAG`, `BTN_RESTART`  in  1 each  raw command buttons; asynchronous, active-high.
- `ACK`  in  8  CPU acknowledge register, from memory-mapped address 247.
- `ACTION`  out  8  action mailbox, read by the CPU at address 246.
- `CURSOR`  out  6  current cell index, `row*COLS + col`.
- `BUSY`  out  1  high while in POST or CLEAR.
- `OVERFLOW`  out  1  sticky; set when a command press is lost.

Behaviour:
- **Reset (`RESET_N` low, asynchronous):**
  - `ACTION`=0x00, `CURSOR`=0, `BUSY`=0, `OVERFLOW`=0.
  - FSM goes to IDLE, the holding buffer is emptied, and the debounced levels and counters are cleared.
  - Reset asserted mid-handshake abandons the pending action.
- **Button conditioning (each of the 7 buttons):**
  - 2-flop synchronizer, then a counter that counts while the synchronized level differs from the debounced level. Any match clears the counter.
  - When the counter equals `DEBOUNCE_CYCLES-1` and the levels still differ, the debounced level flips on the next edge and the counter clears.
  - A press event is a one-cycle pulse on a debounced 0→1 transition. Release generates nothing.
  - Pulses shorter than `DEBOUNCE_CYCLES` produce no event.
- **Cursor (`col`, `row` registers):**
  - Moves on press events regardless of FSM state, and is updated the cycle after the event.
  - RIGHT: col+1, wraps `COLS-1`→0. LEFT: col-1, wraps 0→`COLS-1`. DOWN: row+1, wraps `ROWS-1`→0. UP: row-1, wraps 0→`ROWS-1`.
  - Simultaneous move events in one cycle: only one is applied. Priority is UP > DOWN > LEFT > RIGHT; the others are discarded.
  - `CURSOR` = `row*COLS + col` (registered), zero-extended to 6 bits.
- **Action encoding:**
  - `ACTION[7:6]`: 01 reveal, 10 flag, 11 restart.
  - `ACTION[5:0]`: the cursor index captured in the same cycle as the press event. Restart always uses index 0.
  - 0x00 means "no action".
  - Simultaneous command events: only one is taken, priority RESTART > REVEAL > FLAG.
- **FSM:**
  - **IDLE:** `ACTION`=0.
    - If the buffer is valid: load `ACTION` from the buffer, empty the buffer, go to POST.
    - Otherwise, on a command event: load `ACTION`, go to POST.
    - Latency: event in cycle t → `ACTION` valid at t+1.
  - **POST:** `ACTION` held stable.
    - When `ACK == ACTION`: `ACTION`←0 next cycle, go to CLEAR.
    - Any other `ACK` value is ignored.
  - **CLEAR:** `ACTION`=0.
    - When `ACK == 0x00`: go to IDLE.
    - A valid buffer is posted in the IDLE cycle that follows, i.e. 2 cycles after `ACK`=0 is seen.
  - A restart posted from IDLE or from the buffer also forces col=row=0 in the same edge that loads `ACTION`.
- **Holding buffer (one entry):**
  - A command event in POST or CLEAR is stored in the buffer (command plus the cursor index at press time) if the buffer is empty.
  - If the buffer is full, the event is dropped and `OVERFLOW`←1.
  - `OVERFLOW` clears only on reset.
- **`BUSY`:** 1 exactly in POST and CLEAR.

Test Plan (`DEBOUNCE_CYCLES`=4, `COLS`=16, `ROWS`=4):
- **Move and reveal:** press RIGHT ×3, DOWN ×1, each held 10 cycles → `CURSOR`=19. Then press REVEAL → `ACTION`=0x53 and `BUSY`=1 one cycle after the event.
- **Handshake:** with `ACTION`=0x53, drive `ACK`=0x52 → `ACTION` unchanged. Drive `ACK`=0x53 → next cycle `ACTION`=0x00. Drive `ACK`=0x00 → IDLE, `BUSY`=0.
- **Wrap:** from reset, press LEFT → `CURSOR`=15. Then press UP → `CURSOR`=63. Then press RIGHT → `CURSOR`=48.
- **Buffer:**
  - While 0x53 is in POST, move the cursor to 5 and press FLAG → buffered.
  - Complete the handshake → `ACTION`=0x85 two cycles after `ACK`=0.
  - A second and third command during that POST → `OVERFLOW`=1.
- **Bounce/priority:** a 3-cycle REVEAL glitch → no action. Simultaneous REVEAL+FLAG events → `ACTION`=0x40|idx. Simultaneous UP+RIGHT → only the row changes.
- **Reset and restart:** drop `RESET_N` during POST → `ACTION`=0x00 and `CURSOR`=0 immediately (before any `CLK` edge). Press RESTART at cursor 37 → `ACTION`=0xC0 and `CURSOR`=0.
